// File: rtl/core_status_pkg.sv
// core_status_pkg -- status codes and capture-state encoding shared by the
// core, the status logger and the bench.
//   status_t     : 2-bit per-instruction status code
//   cap_state_t  : capture FSM state of core_status_logger
//   is_terminal  : true for codes that end the program (overflow / end)
package core_status_pkg;

  typedef logic [1:0] status_t;

  localparam status_t R_TYPE_SUCCESS = 2'd0;
  localparam status_t I_TYPE_SUCCESS = 2'd1;
  localparam status_t MIPS_OVERFLOW  = 2'd2;
  localparam status_t MIPS_END       = 2'd3;

  typedef enum logic {
    ST_CAPTURE = 1'b0,
    ST_DONE    = 1'b1
  } cap_state_t;

  function automatic logic is_terminal(input status_t code);
    return (code == MIPS_OVERFLOW) || (code == MIPS_END);
  endfunction

endpackage

// File: rtl/status_fifo_mem.sv
// status_fifo_mem -- DEPTH x 2 status FIFO with wrap-bit pointers.
// Callers present already-accepted push/pop strobes; this block only stores,
// advances pointers and derives full/empty/count.
//   clk, rst_n        : clock, synchronous active-low reset
//   wr_en, wr_data    : accepted push and its code
//   rd_en             : accepted pop (never asserted while empty)
//   rd_data, rd_valid : registered pop result, valid for one cycle
//   full, empty, count: occupancy state derived from the pointers
module status_fifo_mem
  import core_status_pkg::*;
#(
  parameter int DEPTH = 128
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  status_t                  wr_data,
  input  logic                     rd_en,
  output status_t                  rd_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  status_t        mem_r [DEPTH];
  logic [AW:0]    wr_ptr_r;
  logic [AW:0]    rd_ptr_r;
  status_t        rd_data_r;
  logic           rd_valid_r;

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
    end
  end

  // Pointer advance and registered read port; the MSB toggles on wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      rd_data_r  <= R_TYPE_SUCCESS;
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= rd_en;
      if (wr_en) begin
        wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      end
      if (rd_en) begin
        rd_data_r <= mem_r[rd_ptr_r[AW-1:0]];
        rd_ptr_r  <= rd_ptr_r + (AW+1)'(1);
      end
    end
  end

  assign empty    = (wr_ptr_r == rd_ptr_r);
  assign full     = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                    (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign count    = wr_ptr_r - rd_ptr_r;
  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;

endmodule

// File: rtl/core_status_logger.sv
// core_status_logger -- captures the core's per-instruction status stream into
// a FIFO, freezes capture once a terminal code (overflow / end) is seen, and
// keeps sticky drop/done flags plus optional per-type success counters.
// Optional feature macro: STATUS_LOG_CNT_EN (builds o_r_cnt / o_i_cnt logic;
// when undefined both counters are tied to 0).
//   i_clk, i_rst_n            : clock, synchronous active-low reset
//   i_status, i_status_valid  : status stream from the core
//   i_rd_en                   : pop request
//   o_rd_data, o_rd_valid     : popped code, 1-cycle valid pulse
//   o_empty, o_full, o_count  : FIFO occupancy
//   o_drop                    : sticky, a valid code was lost to a full FIFO
//   o_done, o_term_code       : sticky terminal flag and the terminal code
//   o_r_cnt, o_i_cnt          : R-type / I-type success counts (saturating)
module core_status_logger
  import core_status_pkg::*;
#(
  parameter int DEPTH = 128,
  parameter int CNT_W = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  status_t                 i_status,
  input  logic                    i_status_valid,
  input  logic                    i_rd_en,
  output status_t                 o_rd_data,
  output logic                    o_rd_valid,
  output logic                    o_empty,
  output logic                    o_full,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic                    o_drop,
  output logic                    o_done,
  output status_t                 o_term_code,
  output logic [CNT_W-1:0]        o_r_cnt,
  output logic [CNT_W-1:0]        o_i_cnt
);

  cap_state_t state_r;
  logic       done_r;
  status_t    term_code_r;
  logic       drop_r;

  logic       empty_s;
  logic       full_s;
  logic       gate_s;
  logic       pop_s;
  logic       push_s;
  logic       drop_evt_s;
  logic       term_evt_s;

  // Accept logic: a push may use the slot freed by a same-cycle pop, but a pop
  // on an empty FIFO never sees the same-cycle push (no bypass).
  always_comb begin
    gate_s     = i_status_valid & ~done_r;
    pop_s      = i_rd_en & ~empty_s;
    push_s     = gate_s & (~full_s | pop_s);
    drop_evt_s = gate_s & full_s & ~pop_s;
    term_evt_s = gate_s & is_terminal(i_status);
  end

  status_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .wr_en    (push_s),
    .wr_data  (i_status),
    .rd_en    (pop_s),
    .rd_data  (o_rd_data),
    .rd_valid (o_rd_valid),
    .full     (full_s),
    .empty    (empty_s),
    .count    (o_count)
  );

  // Capture FSM: a terminal code passing the done gate freezes capture, even
  // if the code itself was dropped for full. Only reset re-opens capture.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r     <= ST_CAPTURE;
      done_r      <= 1'b0;
      term_code_r <= R_TYPE_SUCCESS;
    end else begin
      case (state_r)
        ST_CAPTURE: begin
          if (term_evt_s) begin
            state_r     <= ST_DONE;
            done_r      <= 1'b1;
            term_code_r <= i_status;
          end
        end
        ST_DONE: begin
          done_r <= 1'b1;
        end
        default: begin
          state_r     <= ST_DONE;
          done_r      <= 1'b1;
          term_code_r <= term_code_r;
        end
      endcase
    end
  end

  // Sticky drop flag.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      drop_r <= 1'b0;
    end else if (drop_evt_s) begin
      drop_r <= 1'b1;
    end
  end

`ifdef STATUS_LOG_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_cnt_r;
  logic [CNT_W-1:0] i_cnt_r;

  // Per-type success counters; they count every gated code, dropped or not.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt_r <= '0;
      i_cnt_r <= '0;
    end else if (gate_s) begin
      if ((i_status == R_TYPE_SUCCESS) && (r_cnt_r != CNT_MAX)) begin
        r_cnt_r <= r_cnt_r + CNT_W'(1);
      end
      if ((i_status == I_TYPE_SUCCESS) && (i_cnt_r != CNT_MAX)) begin
        i_cnt_r <= i_cnt_r + CNT_W'(1);
      end
    end
  end

  assign o_r_cnt = r_cnt_r;
  assign o_i_cnt = i_cnt_r;
`else
  assign o_r_cnt = '0;
  assign o_i_cnt = '0;
`endif

  assign o_empty     = empty_s;
  assign o_full      = full_s;
  assign o_drop      = drop_r;
  assign o_done      = done_r;
  assign o_term_code = term_code_r;

endmodule

// File: tb/tb_core_status_logger.sv
// tb_core_status_logger -- directed-vector bench for core_status_logger.
// Inputs change 1 time unit after each rising edge; outputs are sampled at the
// same point, i.e. they reflect the edge just taken.
module tb_core_status_logger;

  localparam int DEPTH = 128;
  localparam int CNT_W = 16;
`ifdef STATUS_LOG_CNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif

  logic                    i_clk;
  logic                    i_rst_n;
  logic [1:0]              i_status;
  logic                    i_status_valid;
  logic                    i_rd_en;
  logic [1:0]              o_rd_data;
  logic                    o_rd_valid;
  logic                    o_empty;
  logic                    o_full;
  logic [$clog2(DEPTH):0]  o_count;
  logic                    o_drop;
  logic                    o_done;
  logic [1:0]              o_term_code;
  logic [CNT_W-1:0]        o_r_cnt;
  logic [CNT_W-1:0]        o_i_cnt;

  int vec_cnt = 0;
  int err_cnt = 0;

  core_status_logger #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_status       (i_status),
    .i_status_valid (i_status_valid),
    .i_rd_en        (i_rd_en),
    .o_rd_data      (o_rd_data),
    .o_rd_valid     (o_rd_valid),
    .o_empty        (o_empty),
    .o_full         (o_full),
    .o_count        (o_count),
    .o_drop         (o_drop),
    .o_done         (o_done),
    .o_term_code    (o_term_code),
    .o_r_cnt        (o_r_cnt),
    .o_i_cnt        (o_i_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs applied; returns 1 unit after the edge.
  task automatic cyc(input logic v, input logic [1:0] s, input logic r);
    i_status_valid = v;
    i_status       = s;
    i_rd_en        = r;
    @(posedge i_clk);
    #1;
    i_status_valid = 1'b0;
    i_status       = 2'd0;
    i_rd_en        = 1'b0;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    cyc(1'b0, 2'd0, 1'b0);
    i_rst_n = 1'b1;
  endtask

  logic [1:0] seq5 [5];
  logic [1:0] term_seq [5];

  initial begin
    i_rst_n = 1'b1;
    i_status = 2'd0;
    i_status_valid = 1'b0;
    i_rd_en = 1'b0;
    seq5     = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd1};
    term_seq = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1};
    #2;

    // Reset state
    do_reset();
    check_vec("rst_empty", o_empty, 1);
    check_vec("rst_full", o_full, 0);
    check_vec("rst_count", o_count, 0);
    check_vec("rst_rd_valid", o_rd_valid, 0);
    check_vec("rst_rd_data", o_rd_data, 0);
    check_vec("rst_drop", o_drop, 0);
    check_vec("rst_done", o_done, 0);
    check_vec("rst_term", o_term_code, 0);
    check_vec("rst_r_cnt", o_r_cnt, 0);
    check_vec("rst_i_cnt", o_i_cnt, 0);

    // Five pushes then five pops, in order, one-cycle latency
    for (int k = 0; k < 5; k++) cyc(1'b1, seq5[k], 1'b0);
    check_vec("p5_count", o_count, 5);
    check_vec("p5_rd_valid", o_rd_valid, 0);
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, 2'd0, 1'b1);
      check_vec("p5_pop_valid", o_rd_valid, 1);
      check_vec("p5_pop_data", o_rd_data, seq5[k]);
    end
    check_vec("p5_count_end", o_count, 0);
    check_vec("p5_empty_end", o_empty, 1);
    cyc(1'b0, 2'd0, 1'b0);
    check_vec("p5_valid_pulse", o_rd_valid, 0);
    check_vec("p5_r_cnt", o_r_cnt, 2 * CNT_ON);
    check_vec("p5_i_cnt", o_i_cnt, 3 * CNT_ON);

    // Overfill: DEPTH+2 pushes, no pops
    do_reset();
    for (int k = 0; k < DEPTH + 2; k++) cyc(1'b1, 2'd0, 1'b0);
    check_vec("ovf_full", o_full, 1);
    check_vec("ovf_count", o_count, DEPTH);
    check_vec("ovf_drop", o_drop, 1);
    check_vec("ovf_r_cnt", o_r_cnt, (DEPTH + 2) * CNT_ON);

    // Exactly full, then simultaneous push+pop
    do_reset();
    for (int k = 0; k < DEPTH; k++) cyc(1'b1, 2'd0, 1'b0);
    check_vec("fill_full", o_full, 1);
    check_vec("fill_drop", o_drop, 0);
    cyc(1'b1, 2'd1, 1'b1);
    check_vec("fpp_count", o_count, DEPTH);
    check_vec("fpp_drop", o_drop, 0);
    check_vec("fpp_rd_valid", o_rd_valid, 1);
    check_vec("fpp_rd_data", o_rd_data, 0);
    for (int k = 0; k < DEPTH; k++) cyc(1'b0, 2'd0, 1'b1);
    check_vec("fpp_last_data", o_rd_data, 1);
    check_vec("fpp_last_valid", o_rd_valid, 1);
    check_vec("fpp_drain_count", o_count, 0);
    check_vec("fpp_drain_empty", o_empty, 1);
    check_vec("fpp_i_cnt", o_i_cnt, CNT_ON);

    // Terminal code freezes capture
    do_reset();
    for (int k = 0; k < 5; k++) cyc(1'b1, term_seq[k], 1'b0);
    check_vec("term_done", o_done, 1);
    check_vec("term_code", o_term_code, 3);
    check_vec("term_count", o_count, 3);
    check_vec("term_r_cnt", o_r_cnt, CNT_ON);
    check_vec("term_i_cnt", o_i_cnt, CNT_ON);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 2'd0, 1'b1);
      check_vec("term_pop_valid", o_rd_valid, 1);
      check_vec("term_pop_data", o_rd_data, term_seq[k]);
    end
    check_vec("term_empty", o_empty, 1);
    cyc(1'b1, 2'd0, 1'b0);
    check_vec("term_frozen_count", o_count, 0);
    // Pop while empty: no pulse, data holds the last popped code
    cyc(1'b0, 2'd0, 1'b1);
    check_vec("ept_valid", o_rd_valid, 0);
    check_vec("ept_hold", o_rd_data, 3);

    // Pop on empty, then push+pop on empty
    do_reset();
    cyc(1'b0, 2'd0, 1'b1);
    check_vec("ept2_valid", o_rd_valid, 0);
    cyc(1'b1, 2'd1, 1'b1);
    check_vec("epp_valid", o_rd_valid, 0);
    check_vec("epp_count", o_count, 1);
    cyc(1'b0, 2'd0, 1'b1);
    check_vec("epp_pop_valid", o_rd_valid, 1);
    check_vec("epp_pop_data", o_rd_data, 1);

    // Reset after overflow terminal
    do_reset();
    for (int k = 0; k < 10; k++) cyc(1'b1, 2'd1, 1'b0);
    cyc(1'b1, 2'd2, 1'b0);
    check_vec("ot_done", o_done, 1);
    check_vec("ot_code", o_term_code, 2);
    check_vec("ot_count", o_count, 11);
    do_reset();
    check_vec("rr_done", o_done, 0);
    check_vec("rr_count", o_count, 0);
    check_vec("rr_drop", o_drop, 0);
    check_vec("rr_term", o_term_code, 0);
    check_vec("rr_empty", o_empty, 1);
    check_vec("rr_i_cnt", o_i_cnt, 0);
    cyc(1'b1, 2'd0, 1'b0);
    check_vec("rr_push_count", o_count, 1);
    check_vec("rr_push_empty", o_empty, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
